// File: rtl/bit_slice_1bit.sv
// One-bit ALU slice: full adder plus operation select, with registered result and carry.
// Chained through cin/cout to build a full-width MIPS ALU.

module add_1bit (
  input  logic a,
  input  logic bin,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ bin ^ cin;
  assign carry = (a & bin) | (a & cin) | (bin & cin);
endmodule

module mux_5bit (
  input  logic [2:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      default: y = 1'b0;
    endcase
  end
endmodule

module bit_slice_1bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] cntrl,
  output logic       out,
  output logic       cout
);
  logic bin_c;
  logic sum_c;
  logic carry_c;
  logic xor_c;
  logic mul_c;
  logic res_c;
  logic out_p0;
  logic cout_p0;

  // Odd opcodes (SUB, SLT) invert B; the LSB carry-in comes from the ALU top.
  assign bin_c = b ^ cntrl[0];
  assign xor_c = a ^ b;
  assign mul_c = a & b;

  add_1bit u_add (
    .a     (a),
    .bin   (bin_c),
    .cin   (cin),
    .sum   (sum_c),
    .carry (carry_c)
  );

  mux_5bit u_mux (
    .sel (cntrl),
    .d0  (sum_c),
    .d1  (sum_c),
    .d2  (xor_c),
    .d3  (sum_c),
    .d4  (mul_c),
    .y   (res_c)
  );

  // Stage p0: result and carry registered; carry is the adder's for every opcode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p0  <= 1'b0;
      cout_p0 <= 1'b0;
    end else begin
      out_p0  <= res_c;
      cout_p0 <= carry_c;
    end
  end

  assign out  = out_p0;
  assign cout = cout_p0;
endmodule

// File: tb/tb_bit_slice_1bit.sv
// Self-checking bench for bit_slice_1bit: directed vector table, hold check,
// and randomized stimulus against an arithmetic reference model.

module tb_bit_slice_1bit;
  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       cin;
  logic [2:0] cntrl;
  logic       out;
  logic       cout;

  int vectors;
  int miscompares;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cin;
    logic [2:0] cntrl;
    logic       exp_out;
    logic       exp_cout;
  } vec_t;

  vec_t vq[$];

  bit_slice_1bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .cntrl (cntrl),
    .out   (out),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the slice as integer addition of a, (b inverted for odd
  // opcodes) and cin, then pick the result by opcode.
  function automatic void model(input logic r, input logic ai, input logic bi,
                                input logic ci, input logic [2:0] op,
                                output logic mo, output logic mc);
    int bb;
    int total;
    bb    = (op % 2 == 1) ? (1 - int'(bi)) : int'(bi);
    total = int'(ai) + bb + int'(ci);
    if (!r) begin
      mo = 1'b0;
      mc = 1'b0;
    end else begin
      mc = (total >= 2);
      case (op)
        3'd0, 3'd1, 3'd3: mo = (total % 2 == 1);
        3'd2:             mo = (ai != bi);
        3'd4:             mo = (int'(ai) * int'(bi) == 1);
        default:          mo = 1'b0;
      endcase
    end
  endfunction

  task automatic check(input string name, input logic eo, input logic ec);
    vectors++;
    if (out !== eo || cout !== ec) begin
      miscompares++;
      $display("FAIL %s: got out=%0b cout=%0b, want out=%0b cout=%0b",
               name, out, cout, eo, ec);
    end
  endtask

  task automatic drive(input logic r, input logic ai, input logic bi,
                       input logic ci, input logic [2:0] op);
    rst_n = r;
    a     = ai;
    b     = bi;
    cin   = ci;
    cntrl = op;
  endtask

  task automatic step_check(input string name, input logic r, input logic ai,
                            input logic bi, input logic ci, input logic [2:0] op,
                            input logic eo, input logic ec);
    drive(r, ai, bi, ci, op);
    @(posedge clk);
    #1;
    check(name, eo, ec);
  endtask

  initial begin
    logic eo;
    logic ec;
    logic ra;
    logic rb;
    logic rc;
    logic rr;
    logic [2:0] rop;

    vectors     = 0;
    miscompares = 0;

    //         name            rst a  b  cin op  out cout
    vq.push_back('{"rst_hold0",  0, 1, 1, 1, 0, 0, 0});
    vq.push_back('{"rst_hold1",  0, 1, 1, 1, 0, 0, 0});
    vq.push_back('{"rst_release",1, 1, 1, 1, 0, 1, 1});
    vq.push_back('{"sub_a1c0",   1, 1, 1, 0, 1, 1, 0});
    vq.push_back('{"sub_a0c0",   1, 0, 1, 0, 1, 0, 0});
    vq.push_back('{"sub_a0c1",   1, 0, 1, 1, 1, 1, 0});
    vq.push_back('{"sub_a1c1",   1, 1, 1, 1, 1, 0, 1});
    vq.push_back('{"add_000",    1, 0, 0, 0, 0, 0, 0});
    vq.push_back('{"add_001",    1, 0, 0, 1, 0, 1, 0});
    vq.push_back('{"add_010",    1, 0, 1, 0, 0, 1, 0});
    vq.push_back('{"add_011",    1, 0, 1, 1, 0, 0, 1});
    vq.push_back('{"add_100",    1, 1, 0, 0, 0, 1, 0});
    vq.push_back('{"add_101",    1, 1, 0, 1, 0, 0, 1});
    vq.push_back('{"add_110",    1, 1, 1, 0, 0, 0, 1});
    vq.push_back('{"add_111",    1, 1, 1, 1, 0, 1, 1});
    vq.push_back('{"xor_a1b0c1", 1, 1, 0, 1, 2, 1, 1});
    vq.push_back('{"mul_a1b0c1", 1, 1, 0, 1, 4, 0, 1});
    vq.push_back('{"mul_a1b1",   1, 1, 1, 0, 4, 1, 1});
    vq.push_back('{"slt_a0b1c1", 1, 0, 1, 1, 3, 1, 0});
    // Unused opcodes give out=0; cout follows the adder with b inverted on odd ops.
    vq.push_back('{"op5_a1b1",   1, 1, 1, 0, 5, 0, 0});
    vq.push_back('{"op6_a1b1",   1, 1, 1, 0, 6, 0, 1});
    vq.push_back('{"op7_a1b1",   1, 1, 1, 0, 7, 0, 0});
    vq.push_back('{"pre_midrst", 1, 1, 1, 1, 0, 1, 1});
    vq.push_back('{"midrst",     0, 1, 1, 1, 0, 0, 0});
    vq.push_back('{"post_midrst",1, 1, 1, 1, 0, 1, 1});

    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++)
      step_check(vq[i].name, vq[i].rst_n, vq[i].a, vq[i].b, vq[i].cin,
                 vq[i].cntrl, vq[i].exp_out, vq[i].exp_cout);

    // Outputs hold between edges even when inputs change mid-cycle.
    step_check("hold_setup", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    #2;
    check("hold_midcycle", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("hold_update", 1'b1, 1'b1);

    // Reset dominating a back-to-back operation stream, then immediate resume.
    step_check("seq_run", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step_check("seq_rst", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    step_check("seq_resume", 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 15) != 0);
      ra  = $urandom_range(0, 1);
      rb  = $urandom_range(0, 1);
      rc  = $urandom_range(0, 1);
      rop = 3'($urandom_range(0, 7));
      model(rr, ra, rb, rc, rop, eo, ec);
      step_check("random", rr, ra, rb, rc, rop, eo, ec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
